// File: rtl/fetch_pc_unit.sv
// fetch_pc_unit
//   Program-counter and fetch-control stage feeding the instruction memory of
//   the single-cycle RV32 core. Holds the byte-addressed PC and drives it as
//   the memory read address. Each cycle it picks the next PC (sequential,
//   redirect or hold), qualifies the returned instruction for decode, detects
//   EBREAK halts and fetch faults, and counts issued fetches.
//
// Parameters
//   RESET_PC    word-aligned PC loaded on reset
//   IMEM_DEPTH  instruction memory depth in 32-bit words
//
// Ports
//   clk, rst_n       rising-edge clock, asynchronous active-low reset
//   stall            hold the PC this cycle
//   redirect_valid   take redirect_target as the next PC
//   redirect_target  byte address of the branch/jump target
//   resume           one-cycle pulse that leaves HALT
//   instr            word returned combinationally by the memory for pc
//   pc, pc_plus4     current PC and PC + 4 (mod 2^32)
//   instr_out        instr when instr_valid, otherwise NOP
//   instr_valid      instr_out is a real instruction for decode
//   halted, fault    registered-state decodes of HALT and FAULT
//   fault_addr       offending next-PC captured on fault entry
//   fetch_count      saturating count of valid fetches since reset
//   dbg_state        current FSM state (BOOT=0, RUN=1, HALT=2, FAULT=3)
//
// Handshake: a redirect is a level request qualified only by !stall. While
//   stall is high the redirect is neither taken nor dropped; the producer
//   keeps redirect_valid/redirect_target stable until the first cycle with
//   stall low, and the redirect is taken on that cycle's rising edge.

module fetch_pc_unit #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int          IMEM_DEPTH = 256
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        stall,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_target,
  input  logic        resume,
  input  logic [31:0] instr,
  output logic [31:0] pc,
  output logic [31:0] pc_plus4,
  output logic [31:0] instr_out,
  output logic        instr_valid,
  output logic        halted,
  output logic        fault,
  output logic [31:0] fault_addr,
  output logic [31:0] fetch_count,
  output logic [1:0]  dbg_state
);

  localparam logic [31:0] NOP_INSTR    = 32'h0000_0013;
  localparam logic [31:0] EBREAK_INSTR = 32'h0010_0073;
  // 33-bit limit so a depth covering the full 4 GiB space never wraps to 0.
  localparam logic [32:0] PC_LIMIT     = 33'(IMEM_DEPTH) * 33'd4;

  typedef enum logic [1:0] {
    ST_BOOT  = 2'd0,
    ST_RUN   = 2'd1,
    ST_HALT  = 2'd2,
    ST_FAULT = 2'd3
  } state_t;

  state_t      state, state_next;
  logic [31:0] pc_next;
  logic [31:0] fault_addr_next;
  logic [31:0] cand;
  logic        is_ebreak;

  // Misaligned or beyond the end of memory. The wrap of pc + 4 to 0 is only
  // illegal when 0 itself is out of range, which the unsigned compare handles.
  function automatic logic bad_pc(input logic [31:0] a);
    return (a[1:0] != 2'b00) || ({1'b0, a} >= PC_LIMIT);
  endfunction

  assign pc_plus4    = pc + 32'd4;
  assign instr_valid = (state == ST_RUN) && !stall;
  assign instr_out   = instr_valid ? instr : NOP_INSTR;
  assign is_ebreak   = instr_valid && (instr == EBREAK_INSTR);
  assign halted      = (state == ST_HALT);
  assign fault       = (state == ST_FAULT);
  assign dbg_state   = state;

  always_comb begin
    state_next      = state;
    pc_next         = pc;
    fault_addr_next = fault_addr;
    cand            = pc_plus4;
    case (state)
      ST_BOOT: state_next = ST_RUN;
      ST_RUN: begin
        if (!stall) begin
          cand = redirect_valid ? redirect_target : pc_plus4;
          if (is_ebreak) begin
            // EBREAK parks the PC on itself; only an illegal redirect
            // issued alongside it wins over the halt.
            if (redirect_valid && bad_pc(cand)) begin
              state_next      = ST_FAULT;
              fault_addr_next = cand;
            end else begin
              state_next = ST_HALT;
            end
          end else if (bad_pc(cand)) begin
            state_next      = ST_FAULT;
            fault_addr_next = cand;
          end else begin
            pc_next = cand;
          end
        end
      end
      ST_HALT: begin
        if (resume) begin
          cand = pc_plus4;
          if (bad_pc(cand)) begin
            state_next      = ST_FAULT;
            fault_addr_next = cand;
          end else begin
            state_next = ST_RUN;
            pc_next    = cand;
          end
        end
      end
      ST_FAULT: state_next = ST_FAULT;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= ST_BOOT;
      pc          <= RESET_PC;
      fault_addr  <= 32'h0;
      fetch_count <= 32'h0;
    end else begin
      state      <= state_next;
      pc         <= pc_next;
      fault_addr <= fault_addr_next;
      if (instr_valid && (fetch_count != 32'hFFFF_FFFF)) begin
        fetch_count <= fetch_count + 32'd1;
      end
    end
  end

endmodule

// File: tb/tb_fetch_pc_unit.sv
// tb_fetch_pc_unit
//   Bench for fetch_pc_unit. Instance A (RESET_PC=0x10, 256 words) gets
//   directed scenarios and then randomized stimulus compared against a
//   cycle-level behavioural model. Instance B (RESET_PC=0, 4 words) checks
//   the sequential out-of-range fault.

module tb_fetch_pc_unit;

  localparam logic [31:0] NOP     = 32'h0000_0013;
  localparam logic [31:0] EBREAK  = 32'h0010_0073;
  localparam logic [31:0] A_RESET = 32'h0000_0010;
  localparam int          A_DEPTH = 256;
  localparam int          B_DEPTH = 4;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- instance A ----------------
  logic        rst_a, stall_a, rv_a, resume_a;
  logic [31:0] tgt_a, instr_a;
  logic [31:0] pc_a, pc_plus4_a, instr_out_a, fault_addr_a, fetch_count_a;
  logic        instr_valid_a, halted_a, fault_a;
  logic [1:0]  dbg_a;
  logic [31:0] imem [A_DEPTH];

  assign instr_a = imem[pc_a[9:2]];

  fetch_pc_unit #(.RESET_PC(A_RESET), .IMEM_DEPTH(A_DEPTH)) u_dut_a (
    .clk(clk), .rst_n(rst_a), .stall(stall_a), .redirect_valid(rv_a),
    .redirect_target(tgt_a), .resume(resume_a), .instr(instr_a),
    .pc(pc_a), .pc_plus4(pc_plus4_a), .instr_out(instr_out_a),
    .instr_valid(instr_valid_a), .halted(halted_a), .fault(fault_a),
    .fault_addr(fault_addr_a), .fetch_count(fetch_count_a), .dbg_state(dbg_a)
  );

  // ---------------- instance B ----------------
  logic        rst_b, stall_b, rv_b, resume_b;
  logic [31:0] tgt_b, instr_b;
  logic [31:0] pc_b, pc_plus4_b, instr_out_b, fault_addr_b, fetch_count_b;
  logic        instr_valid_b, halted_b, fault_b;
  logic [1:0]  dbg_b;

  fetch_pc_unit #(.RESET_PC(32'h0), .IMEM_DEPTH(B_DEPTH)) u_dut_b (
    .clk(clk), .rst_n(rst_b), .stall(stall_b), .redirect_valid(rv_b),
    .redirect_target(tgt_b), .resume(resume_b), .instr(instr_b),
    .pc(pc_b), .pc_plus4(pc_plus4_b), .instr_out(instr_out_b),
    .instr_valid(instr_valid_b), .halted(halted_b), .fault(fault_b),
    .fault_addr(fault_addr_b), .fetch_count(fetch_count_b), .dbg_state(dbg_b)
  );

  // ---------------- scoreboard ----------------
  int n_vec = 0;
  int n_bad = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // ---------------- reference model (instance A) ----------------
  // Mode flags: booting / halted / faulted; none set means running.
  bit          m_boot, m_halt, m_flt;
  logic [31:0] m_pc, m_faddr, m_count;

  function automatic bit is_bad(input logic [31:0] a, input int depth);
    longint addr;
    addr = longint'({32'h0, a});
    return ((addr % 4) != 0) || (addr >= longint'(depth) * 4);
  endfunction

  task automatic model_reset();
    m_boot  = 1'b1;
    m_halt  = 1'b0;
    m_flt   = 1'b0;
    m_pc    = A_RESET;
    m_faddr = 32'h0;
    m_count = 32'h0;
  endtask

  function automatic bit model_valid();
    return !m_boot && !m_halt && !m_flt && !stall_a;
  endfunction

  // Drive inputs at the falling edge, let them settle, compare all outputs.
  task automatic apply(input bit s, input bit rv, input logic [31:0] t, input bit r);
    bit ev;
    stall_a  = s;
    rv_a     = rv;
    tgt_a    = t;
    resume_a = r;
    #1;
    ev = model_valid();
    check_eq("pc", pc_a, m_pc);
    check_eq("pc_plus4", pc_plus4_a, m_pc + 32'd4);
    check_eq("instr_valid", {31'h0, instr_valid_a}, {31'h0, ev});
    check_eq("instr_out", instr_out_a, ev ? imem[m_pc[9:2]] : NOP);
    check_eq("halted", {31'h0, halted_a}, {31'h0, m_halt});
    check_eq("fault", {31'h0, fault_a}, {31'h0, m_flt});
    check_eq("fault_addr", fault_addr_a, m_faddr);
    check_eq("fetch_count", fetch_count_a, m_count);
  endtask

  // Advance the model over the coming rising edge, then move to the next
  // falling edge.
  task automatic advance();
    logic [31:0] cand;
    bit          brk;
    if (model_valid() && m_count != 32'hFFFF_FFFF) m_count = m_count + 1;
    if (m_boot) begin
      m_boot = 1'b0;
    end else if (m_flt) begin
      // terminal until reset
    end else if (m_halt) begin
      if (resume_a) begin
        cand   = m_pc + 32'd4;
        m_halt = 1'b0;
        if (is_bad(cand, A_DEPTH)) begin
          m_flt   = 1'b1;
          m_faddr = cand;
        end else begin
          m_pc = cand;
        end
      end
    end else if (!stall_a) begin
      cand = rv_a ? tgt_a : m_pc + 32'd4;
      brk  = (imem[m_pc[9:2]] == EBREAK);
      if (brk && !(rv_a && is_bad(cand, A_DEPTH))) begin
        m_halt = 1'b1;
      end else if (is_bad(cand, A_DEPTH)) begin
        m_flt   = 1'b1;
        m_faddr = cand;
      end else begin
        m_pc = cand;
      end
    end
    @(negedge clk);
  endtask

  // Drop reset partway through a low clock phase and check that outputs
  // return to reset values before any rising edge. Ends on a falling edge
  // with the DUT in BOOT.
  task automatic async_reset();
    #2;
    rst_a = 1'b0;
    #1;
    check_eq("rst_pc", pc_a, A_RESET);
    check_eq("rst_instr_valid", {31'h0, instr_valid_a}, 32'h0);
    check_eq("rst_instr_out", instr_out_a, NOP);
    check_eq("rst_halted", {31'h0, halted_a}, 32'h0);
    check_eq("rst_fault", {31'h0, fault_a}, 32'h0);
    check_eq("rst_fault_addr", fault_addr_a, 32'h0);
    check_eq("rst_fetch_count", fetch_count_a, 32'h0);
    model_reset();
    @(negedge clk);
    rst_a = 1'b1;
  endtask

  function automatic logic [31:0] rand_target();
    logic [31:0] t;
    case ($urandom_range(0, 19))
      0:       t = {22'h0, 8'($urandom_range(0, 255)), 2'($urandom_range(1, 3))};
      1:       t = ($urandom | 32'h0000_0400) & 32'hFFFF_FFFC;
      default: t = {22'h0, 8'($urandom_range(0, 255)), 2'b00};
    endcase
    return t;
  endfunction

  // ---------------- stimulus ----------------
  initial begin
    rst_a = 1'b0; stall_a = 1'b0; rv_a = 1'b0; tgt_a = 32'h0; resume_a = 1'b0;
    rst_b = 1'b0; stall_b = 1'b0; rv_b = 1'b0; tgt_b = 32'h0; resume_b = 1'b0;
    instr_b = NOP;
    for (int i = 0; i < A_DEPTH; i++) imem[i] = NOP;
    model_reset();
    @(negedge clk);
    async_reset();

    // Boot and sequential fetch from 0x10.
    apply(0, 0, 32'h0, 0);
    check_eq("boot_pc", pc_a, 32'h10);
    check_eq("boot_valid", {31'h0, instr_valid_a}, 32'h0);
    advance();
    for (int i = 0; i < 3; i++) begin
      apply(0, 0, 32'h0, 0);
      check_eq("seq_pc", pc_a, 32'h10 + 32'(4 * i));
      check_eq("seq_valid", {31'h0, instr_valid_a}, 32'h1);
      advance();
    end

    // Redirect to 0x8, then a redirect held under stall.
    apply(0, 1, 32'h8, 0);
    check_eq("count_after_3", fetch_count_a, 32'd3);
    advance();
    for (int i = 0; i < 2; i++) begin
      apply(1, 1, 32'h40, 0);
      check_eq("stall_pc", pc_a, 32'h8);
      check_eq("stall_valid", {31'h0, instr_valid_a}, 32'h0);
      advance();
    end
    apply(0, 1, 32'h40, 0);
    advance();
    apply(0, 0, 32'h0, 0);
    check_eq("redirect_pc", pc_a, 32'h40);
    advance();

    // EBREAK at 0xC, ignored stall/redirect in HALT, then resume.
    imem[3] = EBREAK;
    apply(0, 1, 32'hC, 0);
    advance();
    apply(0, 0, 32'h0, 0);
    check_eq("ebreak_valid", {31'h0, instr_valid_a}, 32'h1);
    check_eq("ebreak_out", instr_out_a, EBREAK);
    advance();
    apply(1, 1, 32'h80, 0);
    check_eq("halt_flag", {31'h0, halted_a}, 32'h1);
    check_eq("halt_pc", pc_a, 32'hC);
    advance();
    apply(0, 1, 32'h80, 0);
    check_eq("halt_hold_pc", pc_a, 32'hC);
    advance();
    apply(0, 0, 32'h0, 1);
    advance();
    apply(0, 0, 32'h0, 0);
    check_eq("resume_pc", pc_a, 32'h10);
    check_eq("resume_halted", {31'h0, halted_a}, 32'h0);
    check_eq("resume_valid", {31'h0, instr_valid_a}, 32'h1);
    advance();
    imem[3] = NOP;

    // Misaligned redirect into FAULT.
    apply(0, 1, 32'h22, 0);
    advance();
    for (int i = 0; i < 2; i++) begin
      apply(0, 1, 32'h40, 0);
      check_eq("mis_fault", {31'h0, fault_a}, 32'h1);
      check_eq("mis_addr", fault_addr_a, 32'h22);
      check_eq("mis_pc", pc_a, 32'h14);
      check_eq("mis_valid", {31'h0, instr_valid_a}, 32'h0);
      advance();
    end

    // Asynchronous reset out of FAULT, BOOT repeats.
    async_reset();
    apply(0, 0, 32'h0, 0);
    check_eq("reboot_valid", {31'h0, instr_valid_a}, 32'h0);
    advance();
    apply(0, 0, 32'h0, 0);
    check_eq("reboot_pc", pc_a, 32'h10);
    advance();

    // Randomized traffic against the model.
    for (int i = 0; i < A_DEPTH; i++)
      imem[i] = ($urandom_range(0, 5) == 0) ? EBREAK : $urandom;
    for (int n = 0; n < 1500; n++) begin
      if ((m_flt && $urandom_range(0, 3) == 0) || $urandom_range(0, 149) == 0) begin
        async_reset();
      end else begin
        apply(($urandom_range(0, 3) == 0), ($urandom_range(0, 3) == 0),
              rand_target(), ($urandom_range(0, 2) == 0));
        advance();
      end
    end

    // Instance B: run sequentially off the end of a 4-word memory.
    rst_b = 1'b1;
    for (int i = 0; i < 5; i++) begin
      #1;
      check_eq("b_pc", pc_b, (i == 0) ? 32'h0 : 32'(4 * (i - 1)));
      check_eq("b_valid", {31'h0, instr_valid_b}, (i == 0) ? 32'h0 : 32'h1);
      @(negedge clk);
    end
    for (int i = 0; i < 2; i++) begin
      #1;
      check_eq("b_fault", {31'h0, fault_b}, 32'h1);
      check_eq("b_fault_addr", fault_addr_b, 32'h10);
      check_eq("b_pc_hold", pc_b, 32'hC);
      check_eq("b_valid_off", {31'h0, instr_valid_b}, 32'h0);
      check_eq("b_count", fetch_count_b, 32'd4);
      @(negedge clk);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/fetch_pc_unit.md
# fetch_pc_unit

Program-counter and fetch-control stage directly upstream of the instruction memory in the single-cycle RV32 core. It holds the byte-addressed PC and drives it as the memory read address. Each cycle it selects the next PC (sequential, redirect or hold), qualifies the returned instruction toward decode, detects EBREAK halts and fetch faults, and counts issued fetches.

## Interface
- RESET_PC, 32'h0000_0000: PC value loaded on reset; must be word-aligned.
- IMEM_DEPTH, 256: instruction memory depth in 32-bit words; legal PC range is 0 to IMEM_DEPTH*4-4.
- clk  in  1  rising-edge clock.
- rst_n  in  1  reset, asynchronous, active-low.
- stall  in  1  hold the PC this cycle.
- redirect_valid  in  1  take a branch or jump this cycle.
- redirect_target  in  32  byte address of the branch or jump target.
- resume  in  1  leave HALT; one-cycle pulse.
- instr  in  32  word returned combinationally by the instruction memory for pc.
- pc  out  32  current PC; drives the instruction memory address; word index is pc[31:2].
- pc_plus4  out  32  pc + 4, modulo 2^32.
- instr_out  out  32  instr when instr_valid, else 32'h0000_0013 (NOP).
- instr_valid  out  1  instr_out is a real instruction for decode.
- halted  out  1  high while in HALT.
- fault  out  1  high while in FAULT.
- fault_addr  out  32  offending next-PC value captured on fault entry.
- fetch_count  out  32  fetches issued since reset; saturating.

## Operation
- States: BOOT, RUN, HALT, FAULT. Reset enters BOOT.
- BOOT lasts exactly one cycle:
  - pc = RESET_PC; instr_valid = 0.
  - Advances to RUN with pc unchanged.
- RUN: instr_valid = 1 when stall = 0.
- Next-PC candidate, in priority order:
  - stall = 1: hold pc. Any redirect is ignored; the producer must hold it until stall is released.
  - redirect_valid = 1: redirect_target.
  - Otherwise: pc_plus4.
- Fault check on the candidate, applied only when the PC would change:
  - Fault if candidate[1:0] != 0, or candidate >= IMEM_DEPTH*4. The unsigned compare catches the 32-bit wrap to 0 only when 0 is out of range; otherwise the wrap is legal.
  - On fault: go to FAULT, pc holds, fault_addr = candidate.
- EBREAK: in RUN with stall = 0 and instr == 32'h0010_0073:
  - instr_valid = 1 that cycle, so the instruction reaches decode once.
  - Next state is HALT; pc holds at the EBREAK address.
  - A fault takes priority only when redirect_valid is also asserted with an illegal target.
- HALT:
  - instr_valid = 0; stall and redirect are ignored.
  - resume = 1: pc <= pc + 4, with the same fault check; go to RUN (or FAULT).
- FAULT is terminal until reset: instr_valid = 0; pc and fault_addr hold.
- fetch_count increments by 1 each cycle that instr_valid = 1, and saturates at 32'hFFFF_FFFF.
- Reset values: pc = RESET_PC, instr_valid = 0, halted = 0, fault = 0, fault_addr = 0, fetch_count = 0, instr_out = NOP.

## Timing
- pc, state, fault_addr and fetch_count are registered and update on the rising edge of clk.
- rst_n low forces reset values immediately, independent of clk, from any state, including mid-stall, HALT or FAULT.
- pc_plus4, instr_out and instr_valid are combinational from the registered state, pc, stall and instr. There is zero-cycle fetch latency: the instruction for pc is valid in the same cycle.
- A redirect sampled at edge N makes pc = redirect_target after edge N. There is no delay slot.
- halted and fault are decoded from the registered state. They assert the cycle after the triggering edge and never together.
- resume sampled outside HALT has no effect.

## Test plan
- Reset/boot:
  - Stimulus: RESET_PC = 0x10; release rst_n.
  - Required: one cycle with pc = 0x10 and instr_valid = 0; then pc = 0x10, 0x14, 0x18 on successive cycles; fetch_count = 3 after three valid cycles.
- Redirect vs stall:
  - Stimulus: at pc = 0x8, assert redirect_valid with target 0x40 and stall = 1 for 2 cycles, then release stall.
  - Required: pc holds 0x8 for 2 cycles with instr_valid = 0; pc = 0x40 on the next cycle.
- EBREAK halt/resume:
  - Stimulus: instr = 32'h0010_0073 at pc = 0xC.
  - Required: one valid cycle, then halted = 1 with pc = 0xC and stall/redirect ignored.
  - Stimulus: pulse resume.
  - Required: pc = 0x10, halted = 0, instr_valid = 1.
- Misaligned redirect:
  - Stimulus: target 0x22.
  - Required: fault = 1, fault_addr = 0x22, pc unchanged, instr_valid = 0 thereafter.
- Out of range:
  - Stimulus: IMEM_DEPTH = 4, run sequentially from 0.
  - Required: pc reaches 0xC; next cycle fault = 1, fault_addr = 0x10, pc = 0xC.
- Async reset:
  - Stimulus: drop rst_n mid-cycle while in FAULT.
  - Required: outputs return to reset values before the next clock edge; BOOT sequence repeats.
